// File: rtl/vending_machine.sv
// Single-product vending controller: collects coin credit, dispenses with change or refunds.
// Optional idle auto-refund is compiled in with the TIMEOUT_EN macro.
module vending_machine #(
  parameter int PRICE = 2
`ifdef TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cancel,
  input  logic       selectSoda,
  input  logic       confirm,
  input  logic [2:0] coins,
  output logic [2:0] outFirst,
  output logic       outSecond
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  localparam logic [3:0] PRICE_U = 4'(PRICE);

  state_t     state_q, state_d;
  logic [2:0] credit_q, credit_d;
  logic [2:0] out_first_q, out_first_d;
  logic       out_second_q, out_second_d;

  logic [3:0] nxt_s;
  logic [2:0] change_s;
  logic       buy_s;
  logic       activity_s;
  logic       timeout_hit_s;

  assign nxt_s      = {1'b0, credit_q} + {1'b0, coins};
  assign change_s   = 3'(nxt_s - PRICE_U);
  assign buy_s      = selectSoda & confirm;
  assign activity_s = (coins != 3'd0) | cancel | selectSoda | confirm;

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;

  assign timeout_hit_s = !activity_s && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter: runs only in COLLECT and restarts on any panel activity.
  always_comb begin
    timer_d = '0;
    if (state_q == COLLECT && !activity_s) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state, credit and output pulse decisions.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    out_first_d  = 3'd0;
    out_second_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COLLECT;
          credit_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        // Cancel wins over everything; the coin offered this cycle is not taken.
        if (cancel) begin
          state_d     = REFUND;
          out_first_d = credit_q;
        end else if (timeout_hit_s) begin
          state_d     = REFUND;
          out_first_d = credit_q;
        end else if (nxt_s > 4'd7) begin
          out_first_d = coins;
        end else if (buy_s && (nxt_s >= PRICE_U)) begin
          state_d      = DISPENSE;
          out_second_d = 1'b1;
          out_first_d  = change_s;
        end else begin
          credit_d = nxt_s[2:0];
        end
      end
      DISPENSE, REFUND: begin
        state_d  = IDLE;
        credit_d = 3'd0;
      end
      default: begin
        state_d  = IDLE;
        credit_d = 3'd0;
      end
    endcase
  end

  // State, credit and registered outputs; reset drops everything without a refund.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      credit_q     <= 3'd0;
      out_first_q  <= 3'd0;
      out_second_q <= 1'b0;
`ifdef TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      out_first_q  <= out_first_d;
      out_second_q <= out_second_d;
`ifdef TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign outFirst  = out_first_q;
  assign outSecond = out_second_q;

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: a transaction-level model predicts output pulses,
// a monitor compares the DUT outputs against them every cycle.
module tb_vending_machine;

  localparam int PRICE = 2;
  localparam int TOUT  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       selectSoda = 1'b0;
  logic       confirm = 1'b0;
  logic [2:0] coins = 3'd0;
  logic [2:0] outFirst;
  logic       outSecond;

  vending_machine #(.PRICE(PRICE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .selectSoda(selectSoda), .confirm(confirm), .coins(coins),
    .outFirst(outFirst), .outSecond(outSecond)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int stamp;
    int first;
    int second;
  } ev_t;
  ev_t exp_q[$];

  int total = 0;
  int bad = 0;

  // Reference model: transaction status plus credit held as plain integers.
  bit m_txn = 1'b0;
  bit m_busy = 1'b0;
  int m_credit = 0;
  int m_idle = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic emit(input int f, input int s);
    ev_t e;
    if (f != 0 || s != 0) begin
      e.stamp = cyc + 1;
      e.first = f;
      e.second = s;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_step(input bit st, input bit can, input bit sel, input bit cf, input int cn);
    int sum;
    bit act;
    bit tout;
    if (m_busy) begin
      m_busy = 1'b0;
      m_txn = 1'b0;
      m_credit = 0;
    end else if (!m_txn) begin
      if (st) begin
        m_txn = 1'b1;
        m_credit = 0;
        m_idle = 0;
      end
    end else begin
      sum = m_credit + cn;
      act = (cn != 0) || can || sel || cf;
      tout = 1'b0;
`ifdef TIMEOUT_EN
      tout = !act && (m_idle + 1 == TOUT);
`endif
      if (can || tout) begin
        emit(m_credit, 0);
        m_busy = 1'b1;
      end else if (sum > 7) begin
        emit(cn, 0);
      end else if (sel && cf && sum >= PRICE) begin
        emit(sum - PRICE, 1);
        m_busy = 1'b1;
      end else begin
        m_credit = sum;
      end
      m_idle = act ? 0 : m_idle + 1;
    end
  endtask

  task automatic step(input bit st, input bit can, input bit sel, input bit cf, input int cn);
    @(negedge clk);
    start = st;
    cancel = can;
    selectSoda = sel;
    confirm = cf;
    coins = 3'(cn);
    model_step(st, can, sel, cf, cn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Monitor: every cycle the outputs must equal the pulse due now, or zero.
  always @(posedge clk) begin
    int ef;
    int es;
    ev_t ev;
    #1;
    ef = 0;
    es = 0;
    while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
      ev = exp_q.pop_front();
      check("stale_pulse", ev.stamp, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
      ev = exp_q.pop_front();
      ef = ev.first;
      es = ev.second;
    end
    check("outFirst", int'(outFirst), ef);
    check("outSecond", int'(outSecond), es);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // held start/coin 2/select/confirm: dispense every third clock
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 2);
    idle(3);

    // coins 3 then 2, buy: change 3
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(2);

    // coin 5 then cancel: refund 5
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(2);

    // credit 6, coin 3 bounced, then buy with change 4
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 6);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(2);

    // credit 1 is short; confirm alone and select alone ignored; coin 1 completes
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1);
    idle(2);

    // reset with credit 4 in COLLECT: outputs clear at once and no refund follows
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk);
    start = 1'b0;
    coins = 3'd0;
    rst_n = 1'b0;
    m_txn = 1'b0;
    m_busy = 1'b0;
    m_credit = 0;
    exp_q.delete();
    #1;
    check("rst_outFirst", int'(outFirst), 0);
    check("rst_outSecond", int'(outSecond), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(2);

`ifdef TIMEOUT_EN
    // credit 2 left alone until the idle limit: auto-refund of 2
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2);
    idle(TOUT + 3);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 7)));
    end
    idle(4);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
